// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
//   SIZE_*      : access size encoding on dsize_i / m_size_o
//   arb_state_e : arbiter FSM states
//   arb_gnt_e   : grant decision produced by riscv_arb_pick
//   run_cnt_w   : width of the data-run counter for a given MAX_DATA_RUN
package riscv_mem_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_I_BUSY = 3'd1,
    ARB_D_BUSY = 3'd2,
    ARB_I_RESP = 3'd3,
    ARB_D_RESP = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } arb_gnt_e;

  // Counter must hold 0..max_run; never narrower than one bit.
  function automatic int run_cnt_w(input int max_run);
    return (max_run < 2) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between core, arbiter and single-ported memory.
//   core fetch : iaddr_i, ird_i -> irdata_o, ivalid_o
//   core data  : daddr_i, dwdata_i, dsize_i, drd_i, dwr_i -> drdata_o, dvalid_o
//   core stall : stall_o
//   memory     : m_addr_o, m_wdata_o, m_size_o, m_rd_o, m_wr_o <- m_rdata_i, m_ready_i
// slave is the arbiter's view; master is the core + memory side.
interface riscv_mem_arbiter_if #(parameter int ADDR_W = 32);

  logic [ADDR_W-1:0] iaddr_i;
  logic              ird_i;
  logic [31:0]       irdata_o;
  logic              ivalid_o;

  logic [ADDR_W-1:0] daddr_i;
  logic [31:0]       dwdata_i;
  logic [1:0]        dsize_i;
  logic              drd_i;
  logic              dwr_i;
  logic [31:0]       drdata_o;
  logic              dvalid_o;

  logic              stall_o;

  logic [ADDR_W-1:0] m_addr_o;
  logic [31:0]       m_wdata_o;
  logic [1:0]        m_size_o;
  logic              m_rd_o;
  logic              m_wr_o;
  logic [31:0]       m_rdata_i;
  logic              m_ready_i;

  modport slave (
    input  iaddr_i, ird_i, daddr_i, dwdata_i, dsize_i, drd_i, dwr_i,
           m_rdata_i, m_ready_i,
    output irdata_o, ivalid_o, drdata_o, dvalid_o, stall_o,
           m_addr_o, m_wdata_o, m_size_o, m_rd_o, m_wr_o
  );

  modport master (
    output iaddr_i, ird_i, daddr_i, dwdata_i, dsize_i, drd_i, dwr_i,
           m_rdata_i, m_ready_i,
    input  irdata_o, ivalid_o, drdata_o, dvalid_o, stall_o,
           m_addr_o, m_wdata_o, m_size_o, m_rd_o, m_wr_o
  );

endinterface

// File: rtl/riscv_arb_pick.sv
// Combinational grant select.
//   ird     : fetch request pending
//   dreq    : load or store pending
//   run_cnt : consecutive data grants made while fetch was waiting
//   gnt     : GNT_D / GNT_I / GNT_NONE
// Data wins a conflict until it has taken MAX_DATA_RUN grants in a row
// over a waiting fetch; MAX_DATA_RUN = 0 hands every conflict to fetch.
module riscv_arb_pick
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4,
  parameter int CNT_W        = run_cnt_w(MAX_DATA_RUN)
) (
  input  logic             ird,
  input  logic             dreq,
  input  logic [CNT_W-1:0] run_cnt,
  output arb_gnt_e         gnt
);

  logic run_ok;

  // run_cnt saturates at MAX_DATA_RUN, so "below the limit" is "not at it".
  assign run_ok = (MAX_DATA_RUN != 0) && (run_cnt != CNT_W'(MAX_DATA_RUN));

  always_comb begin
    gnt = GNT_NONE;
    if (dreq && (!ird || run_ok)) gnt = GNT_D;
    else if (ird)                 gnt = GNT_I;
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
//   clk_i   : clock
//   reset_i : asynchronous reset, active low
//   bus     : riscv_mem_arbiter_if.slave (core fetch/data ports, stall, memory port)
// Every access walks IDLE -> *_BUSY -> *_RESP -> IDLE; memory strobes are
// registered at grant and held until m_ready_i, the valid pulse is the RESP
// state itself.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  riscv_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = run_cnt_w(MAX_DATA_RUN);

  arb_state_e        state_q, state_d;
  arb_gnt_e          gnt;
  logic              dreq;
  logic [CNT_W-1:0]  run_cnt_q;

  logic [ADDR_W-1:0] m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [1:0]        m_size_q;
  logic              m_rd_q, m_wr_q;
  logic [31:0]       irdata_q, drdata_q;

  assign dreq = bus.drd_i | bus.dwr_i;

  riscv_arb_pick #(.MAX_DATA_RUN(MAX_DATA_RUN), .CNT_W(CNT_W)) u_pick (
    .ird     (bus.ird_i),
    .dreq    (dreq),
    .run_cnt (run_cnt_q),
    .gnt     (gnt)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt == GNT_D)      state_d = ARB_D_BUSY;
        else if (gnt == GNT_I) state_d = ARB_I_BUSY;
      end
      ARB_I_BUSY: if (bus.m_ready_i) state_d = ARB_I_RESP;
      ARB_D_BUSY: if (bus.m_ready_i) state_d = ARB_D_RESP;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= SIZE_WORD;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      irdata_q  <= '0;
      drdata_q  <= '0;
      run_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (gnt == GNT_D) begin
            m_addr_q  <= bus.daddr_i;
            m_wdata_q <= bus.dwdata_i;
            m_size_q  <= bus.dsize_i;
            // a simultaneous load+store request is issued as the store
            m_wr_q    <= bus.dwr_i;
            m_rd_q    <= ~bus.dwr_i;
            // only grants that make a waiting fetch wait longer count
            if (bus.ird_i && (run_cnt_q != CNT_W'(MAX_DATA_RUN)))
              run_cnt_q <= run_cnt_q + CNT_W'(1);
          end else if (gnt == GNT_I) begin
            m_addr_q  <= bus.iaddr_i;
            m_wdata_q <= '0;
            m_size_q  <= SIZE_WORD;
            m_rd_q    <= 1'b1;
            m_wr_q    <= 1'b0;
            run_cnt_q <= '0;
          end
        end
        ARB_I_BUSY: begin
          if (bus.m_ready_i) begin
            m_rd_q   <= 1'b0;
            irdata_q <= bus.m_rdata_i;
          end
        end
        ARB_D_BUSY: begin
          if (bus.m_ready_i) begin
            m_rd_q <= 1'b0;
            m_wr_q <= 1'b0;
            if (m_rd_q) drdata_q <= bus.m_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_addr_o  = m_addr_q;
  assign bus.m_wdata_o = m_wdata_q;
  assign bus.m_size_o  = m_size_q;
  assign bus.m_rd_o    = m_rd_q;
  assign bus.m_wr_o    = m_wr_q;
  assign bus.irdata_o  = irdata_q;
  assign bus.drdata_o  = drdata_q;
  assign bus.ivalid_o  = (state_q == ARB_I_RESP);
  assign bus.dvalid_o  = (state_q == ARB_D_RESP);
  assign bus.stall_o   = (bus.ird_i & ~bus.ivalid_o) | (dreq & ~bus.dvalid_o);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: reset state, a vector table of
// isolated accesses, hand-written fairness / reset / handshake sequences and
// a randomized run against a transaction-level reference model.
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;

  localparam int K_FETCH = 0, K_LOAD = 1, K_STORE = 2, K_RW = 3;
  localparam int MAX_RUN = 4;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.ADDR_W(32)) bus ();
  riscv_mem_arbiter_if #(.ADDR_W(32)) bus0 ();

  riscv_mem_arbiter #(.ADDR_W(32), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(bus.slave));
  riscv_mem_arbiter #(.ADDR_W(32), .MAX_DATA_RUN(0)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .bus(bus0.slave));

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          d;          // strobe cycles until memory ready
    logic [31:0] rdata;
    logic        exp_rd;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_wdata;
    int          exp_lat;    // cycle of the valid pulse, request cycle = 0
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vec[6];

  int n_pass = 0, n_total = 0;

  int          lat, scnt;
  logic [31:0] saddr, swdata;
  logic [1:0]  ssize;
  logic        srd, swr, sstall, gi, gd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic clear_req();
    bus.ird_i = 1'b0; bus.drd_i = 1'b0; bus.dwr_i = 1'b0;
  endtask

  task automatic set_req(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size);
    if (kind == K_FETCH) begin
      bus.iaddr_i = addr; bus.ird_i = 1'b1;
    end else begin
      bus.daddr_i = addr; bus.dwdata_i = wdata; bus.dsize_i = size;
      bus.drd_i = (kind == K_LOAD) || (kind == K_RW);
      bus.dwr_i = (kind == K_STORE) || (kind == K_RW);
    end
  endtask

  // Called in an IDLE cycle with requests already driven. Acts as the memory
  // (ready on the d-th strobe cycle) and returns when a valid pulse is seen.
  task automatic do_access(input int d, input logic [31:0] rdata);
    lat = -1; scnt = 0; saddr = '0; swdata = '0; ssize = '0;
    srd = 1'b0; swr = 1'b0; sstall = 1'b0; gi = 1'b0; gd = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.ivalid_o || bus.dvalid_o) begin
        lat = c; gi = bus.ivalid_o; gd = bus.dvalid_o;
        bus.m_ready_i = 1'b0;
        break;
      end
      if (bus.m_rd_o || bus.m_wr_o) begin
        scnt++;
        if (scnt == 1) begin
          saddr = bus.m_addr_o; swdata = bus.m_wdata_o; ssize = bus.m_size_o;
          srd = bus.m_rd_o; swr = bus.m_wr_o; sstall = bus.stall_o;
        end
        bus.m_ready_i = (scnt == d);
        bus.m_rdata_i = (scnt == d) ? rdata : $urandom;
      end else begin
        bus.m_ready_i = 1'b0;
      end
    end
  endtask

  initial begin
    int          run, d, n;
    bit          ip, dp, dw, both, want_d;
    logic [31:0] ia, da, dwd, rd, exp_i, exp_d;
    logic [1:0]  ds;
    string       gseq;

    vec[0] = '{K_FETCH, 32'h10,  32'h0,        SIZE_WORD, 2, 32'h00500093,
               1'b1, 1'b0, SIZE_WORD, 32'h0,        3, 32'h00500093, 32'h0};
    vec[1] = '{K_LOAD,  32'h200, 32'h0,        SIZE_HALF, 1, 32'h0000BEEF,
               1'b1, 1'b0, SIZE_HALF, 32'h0,        2, 32'h00500093, 32'h0000BEEF};
    vec[2] = '{K_STORE, 32'h100, 32'hDEADBEEF, SIZE_WORD, 3, 32'hFFFFFFFF,
               1'b0, 1'b1, SIZE_WORD, 32'hDEADBEEF, 4, 32'h00500093, 32'h0000BEEF};
    vec[3] = '{K_RW,    32'h300, 32'h12345678, SIZE_BYTE, 1, 32'h87654321,
               1'b0, 1'b1, SIZE_BYTE, 32'h12345678, 2, 32'h00500093, 32'h0000BEEF};
    vec[4] = '{K_FETCH, 32'h14,  32'h0,        SIZE_WORD, 4, 32'hCAFEF00D,
               1'b1, 1'b0, SIZE_WORD, 32'h0,        5, 32'hCAFEF00D, 32'h0000BEEF};
    vec[5] = '{K_LOAD,  32'h104, 32'h0,        SIZE_WORD, 2, 32'h11223344,
               1'b1, 1'b0, SIZE_WORD, 32'h0,        3, 32'hCAFEF00D, 32'h11223344};

    reset_i = 1'b0;
    bus.iaddr_i = '0; bus.daddr_i = '0; bus.dwdata_i = '0; bus.dsize_i = '0;
    bus.m_rdata_i = '0; bus.m_ready_i = 1'b0; clear_req();
    bus0.iaddr_i = '0; bus0.daddr_i = '0; bus0.dwdata_i = '0; bus0.dsize_i = '0;
    bus0.m_rdata_i = '0; bus0.m_ready_i = 1'b0;
    bus0.ird_i = 1'b0; bus0.drd_i = 1'b0; bus0.dwr_i = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst strobes/valids/stall",
        {27'b0, bus.m_rd_o, bus.m_wr_o, bus.ivalid_o, bus.dvalid_o, bus.stall_o}, 32'h0);
    chk("rst m_addr", bus.m_addr_o, 32'h0);
    chk("rst m_wdata", bus.m_wdata_o, 32'h0);
    chk("rst m_size", {30'b0, bus.m_size_o}, {30'b0, SIZE_WORD});
    chk("rst irdata", bus.irdata_o, 32'h0);
    chk("rst drdata", bus.drdata_o, 32'h0);
    reset_i = 1'b1;

    // table of isolated accesses
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_req(vec[i].kind, vec[i].addr, vec[i].wdata, vec[i].size);
      do_access(vec[i].d, vec[i].rdata);
      clear_req();
      chk($sformatf("v%0d m_rd", i), {31'b0, srd}, {31'b0, vec[i].exp_rd});
      chk($sformatf("v%0d m_wr", i), {31'b0, swr}, {31'b0, vec[i].exp_wr});
      chk($sformatf("v%0d m_addr", i), saddr, vec[i].addr);
      chk($sformatf("v%0d m_size", i), {30'b0, ssize}, {30'b0, vec[i].exp_size});
      chk($sformatf("v%0d m_wdata", i), swdata, vec[i].exp_wdata);
      chk($sformatf("v%0d stall", i), {31'b0, sstall}, 32'h1);
      chk($sformatf("v%0d strobe cycles", i), scnt, vec[i].d);
      chk($sformatf("v%0d valid cycle", i), lat, vec[i].exp_lat);
      chk($sformatf("v%0d valid port", i), {30'b0, gi, gd},
          (vec[i].kind == K_FETCH) ? 32'h2 : 32'h1);
      chk($sformatf("v%0d irdata", i), bus.irdata_o, vec[i].exp_i);
      chk($sformatf("v%0d drdata", i), bus.drdata_o, vec[i].exp_d);
    end

    // both requests held, MAX_DATA_RUN=4: D,D,D,D,I,D,D,D,D,I
    gseq = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.iaddr_i = 32'h1000; bus.ird_i = 1'b1;
        bus.daddr_i = 32'h2000; bus.dsize_i = SIZE_WORD; bus.drd_i = 1'b1;
      end
      do_access(1, 32'h0BAD0000 + k);
      chk($sformatf("run grant %0d", k), saddr, (gseq[k] == "D") ? 32'h2000 : 32'h1000);
    end
    clear_req();

    // MAX_DATA_RUN=0: every conflict goes to fetch
    bus0.iaddr_i = 32'h3000; bus0.ird_i = 1'b1;
    bus0.daddr_i = 32'h4000; bus0.dsize_i = SIZE_WORD; bus0.drd_i = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(posedge clk); #1;
      if (bus0.m_rd_o) begin
        chk($sformatf("max0 grant %0d", n), bus0.m_addr_o, 32'h3000);
        n++;
        bus0.m_ready_i = 1'b1;
      end else begin
        bus0.m_ready_i = 1'b0;
      end
    end
    chk("max0 grant count", n, 6);
    @(posedge clk); #1;
    bus0.m_ready_i = 1'b0; bus0.ird_i = 1'b0; bus0.drd_i = 1'b0;

    // m_ready_i in IDLE is ignored
    @(posedge clk); #1;
    bus.m_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("idle ready %0d", c),
          {27'b0, bus.m_rd_o, bus.m_wr_o, bus.ivalid_o, bus.dvalid_o, bus.stall_o}, 32'h0);
    end
    bus.m_ready_i = 1'b0;

    // fetch dropped mid-BUSY still completes
    @(posedge clk); #1;
    bus.iaddr_i = 32'h40; bus.ird_i = 1'b1;
    @(posedge clk); #1;
    chk("drop m_rd", {31'b0, bus.m_rd_o}, 32'h1);
    bus.ird_i = 1'b0;
    @(posedge clk); #1;
    chk("drop stall", {31'b0, bus.stall_o}, 32'h0);
    bus.m_ready_i = 1'b1; bus.m_rdata_i = 32'hA5A50001;
    @(posedge clk); #1;
    bus.m_ready_i = 1'b0;
    chk("drop ivalid", {31'b0, bus.ivalid_o}, 32'h1);
    chk("drop irdata", bus.irdata_o, 32'hA5A50001);

    // reset during D_BUSY
    @(posedge clk); #1;
    set_req(K_STORE, 32'h500, 32'h55AA55AA, SIZE_WORD);
    @(posedge clk); #1;
    chk("rstbusy m_wr before", {31'b0, bus.m_wr_o}, 32'h1);
    @(posedge clk); #1;
    reset_i = 1'b0; clear_req();
    #1;
    chk("rstbusy strobes/valids/stall",
        {27'b0, bus.m_rd_o, bus.m_wr_o, bus.ivalid_o, bus.dvalid_o, bus.stall_o}, 32'h0);
    chk("rstbusy m_addr", bus.m_addr_o, 32'h0);
    chk("rstbusy m_wdata", bus.m_wdata_o, 32'h0);
    chk("rstbusy m_size", {30'b0, bus.m_size_o}, {30'b0, SIZE_WORD});
    chk("rstbusy irdata", bus.irdata_o, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rstbusy dvalid %0d", c), {31'b0, bus.dvalid_o}, 32'h0);
    end
    reset_i = 1'b1;
    @(posedge clk); #1;
    set_req(K_LOAD, 32'h600, 32'h0, SIZE_HALF);
    do_access(2, 32'h00007777);
    clear_req();
    chk("post-rst valid cycle", lat, 3);
    chk("post-rst dvalid", {30'b0, gi, gd}, 32'h1);
    chk("post-rst drdata", bus.drdata_o, 32'h00007777);

    // randomized traffic against a transaction-level model
    run = 0; ip = 0; dp = 0; dw = 0; both = 0;
    ia = '0; da = '0; dwd = '0; ds = SIZE_WORD;
    exp_i = 32'h0; exp_d = 32'h00007777;
    for (int t = 0; t < 150; t++) begin
      @(posedge clk); #1;
      if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; ia = $urandom & ~32'h3; end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; da = $urandom; dwd = $urandom; ds = 2'($urandom_range(0, 2));
        dw = 1'($urandom_range(0, 1)); both = ($urandom_range(0, 3) == 0);
      end
      if (!ip && !dp) begin ip = 1; ia = $urandom & ~32'h3; end
      bus.ird_i = ip; bus.iaddr_i = ia;
      bus.daddr_i = da; bus.dwdata_i = dwd; bus.dsize_i = ds;
      bus.drd_i = dp && (!dw || both);
      bus.dwr_i = dp && dw;

      want_d = dp && (!ip || run < MAX_RUN);
      if (want_d) begin
        if (ip) run = (run + 1 > MAX_RUN) ? MAX_RUN : run + 1;
      end else begin
        run = 0;
      end

      d  = $urandom_range(1, 4);
      rd = $urandom;
      do_access(d, rd);

      if (!want_d) exp_i = rd;
      else if (!dw) exp_d = rd;

      chk($sformatf("rnd%0d valid port", t), {30'b0, gi, gd}, want_d ? 32'h1 : 32'h2);
      chk($sformatf("rnd%0d m_addr", t), saddr, want_d ? da : ia);
      chk($sformatf("rnd%0d m_wr", t), {31'b0, swr}, {31'b0, want_d && dw});
      chk($sformatf("rnd%0d m_rd", t), {31'b0, srd}, {31'b0, !(want_d && dw)});
      chk($sformatf("rnd%0d m_size", t), {30'b0, ssize}, {30'b0, want_d ? ds : SIZE_WORD});
      chk($sformatf("rnd%0d m_wdata", t), swdata, want_d ? dwd : 32'h0);
      chk($sformatf("rnd%0d stall", t), {31'b0, sstall}, 32'h1);
      chk($sformatf("rnd%0d strobe cycles", t), scnt, d);
      chk($sformatf("rnd%0d valid cycle", t), lat, d + 1);
      chk($sformatf("rnd%0d irdata", t), bus.irdata_o, exp_i);
      chk($sformatf("rnd%0d drdata", t), bus.drdata_o, exp_d);

      if (want_d) begin dp = 0; bus.drd_i = 1'b0; bus.dwr_i = 1'b0; end
      else begin ip = 0; bus.ird_i = 1'b0; end
    end
    clear_req();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
